// File: rtl/atuador_de_porta.sv
// Door motor actuator: sequences open, hold, close and fault states from the
// open request, limit switches and obstacle sensor, with motion/hold timeouts.
module atuador_de_porta #(
  parameter int T_ESPERA  = 4,
  parameter int T_MAX_MOV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abrir,
  input  logic       fim_aberta,
  input  logic       fim_fechada,
  input  logic       obstaculo,
  input  logic       rearme,
  output logic       motor_abrir,
  output logic       motor_fechar,
  output logic       porta_aberta,
  output logic       alarme,
  output logic [2:0] estado
);

  localparam int MAXT = (T_ESPERA > T_MAX_MOV) ? T_ESPERA : T_MAX_MOV;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam logic [CW-1:0] ESP_LAST = CW'(T_ESPERA - 1);
  localparam logic [CW-1:0] MOV_LAST = CW'(T_MAX_MOV - 1);

  typedef enum logic [2:0] {
    FECHADA  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTA   = 3'd2,
    FECHANDO = 3'd3,
    FALHA    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reload;
  logic          conflito;

  assign conflito = fim_aberta & fim_fechada;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FECHADA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    case (state_q)
      FECHADA: begin
        if (abrir) state_d = ABRINDO;
      end
      ABRINDO: begin
        if (conflito)              state_d = FALHA;
        else if (fim_aberta)       state_d = ABERTA;
        else if (cnt_q == MOV_LAST) state_d = FALHA;
      end
      ABERTA: begin
        if (abrir | obstaculo)      reload  = 1'b1;
        else if (cnt_q == ESP_LAST) state_d = FECHANDO;
      end
      FECHANDO: begin
        // Reversal is checked before the closed switch so a person is never trapped.
        if (conflito)               state_d = FALHA;
        else if (obstaculo | abrir) state_d = ABRINDO;
        else if (fim_fechada)       state_d = FECHADA;
        else if (cnt_q == MOV_LAST) state_d = FALHA;
      end
      FALHA: begin
        if (rearme) state_d = FECHANDO;
      end
      default: state_d = FALHA;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && !reload &&
        ((state_q == ABRINDO) || (state_q == ABERTA) || (state_q == FECHANDO)))
      cnt_d = cnt_q + 1'b1;
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    motor_abrir  = 1'b0;
    motor_fechar = 1'b0;
    porta_aberta = 1'b0;
    alarme       = 1'b0;
    case (state_q)
      ABRINDO:  motor_abrir  = 1'b1;
      ABERTA:   porta_aberta = 1'b1;
      FECHANDO: motor_fechar = 1'b1;
      FALHA:    alarme       = 1'b1;
      default:  ;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_atuador_de_porta.sv
// Scoreboard bench for atuador_de_porta: directed scenarios then random inputs,
// each cycle's expected outputs queued by a reference model and checked by a monitor.
module tb_atuador_de_porta;

  localparam int T_ESPERA  = 4;
  localparam int T_MAX_MOV = 8;

  logic       clk = 1'b0;
  logic       rst, abrir, fim_aberta, fim_fechada, obstaculo, rearme;
  logic       motor_abrir, motor_fechar, porta_aberta, alarme;
  logic [2:0] estado;

  atuador_de_porta #(.T_ESPERA(T_ESPERA), .T_MAX_MOV(T_MAX_MOV)) dut (
    .clk(clk), .rst(rst), .abrir(abrir), .fim_aberta(fim_aberta),
    .fim_fechada(fim_fechada), .obstaculo(obstaculo), .rearme(rearme),
    .motor_abrir(motor_abrir), .motor_fechar(motor_fechar),
    .porta_aberta(porta_aberta), .alarme(alarme), .estado(estado)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: door mode plus cycles spent since entering or refreshing it.
  int m_state = 0;
  int m_time  = 0;

  function automatic logic [6:0] expected_out(input int s);
    logic [6:0] v;
    v = {3'(s), 4'b0000};
    if (s == 1) v[3] = 1'b1;
    if (s == 3) v[2] = 1'b1;
    if (s == 2) v[1] = 1'b1;
    if (s == 4) v[0] = 1'b1;
    return v;
  endfunction

  task automatic model_edge(input logic a, fa, ff, ob, re, r);
    int nxt;
    bit refresh;
    nxt = m_state;
    refresh = 0;
    if (r) begin
      nxt = 0; refresh = 1;
    end else if (m_state == 0) begin
      if (a) nxt = 1;
    end else if (m_state == 1) begin
      if (fa && ff) nxt = 4;
      else if (fa) nxt = 2;
      else if (m_time + 1 >= T_MAX_MOV) nxt = 4;
    end else if (m_state == 2) begin
      if (a || ob) refresh = 1;
      else if (m_time + 1 >= T_ESPERA) nxt = 3;
    end else if (m_state == 3) begin
      if (fa && ff) nxt = 4;
      else if (ob || a) nxt = 1;
      else if (ff) nxt = 0;
      else if (m_time + 1 >= T_MAX_MOV) nxt = 4;
    end else begin
      if (re) nxt = 3;
    end
    if (nxt != m_state || refresh) m_time = 0;
    else m_time = m_time + 1;
    m_state = nxt;
  endtask

  task automatic step(input logic a, fa, ff, ob, re, r);
    @(negedge clk);
    abrir = a; fim_aberta = fa; fim_fechada = ff;
    obstaculo = ob; rearme = re; rst = r;
    model_edge(a, fa, ff, ob, re, r);
    exp_q.push_back(expected_out(m_state));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every rising edge produces one registered output word to check.
  initial begin
    logic [6:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {estado, motor_abrir, motor_fechar, porta_aberta, alarme};
        total++;
        if (got === want && !(motor_abrir && motor_fechar)) passed++;
        else $display("FAIL cyc%0d outputs got=%b exp=%b (estado,ma,mf,pa,al)", cyc, got, want);
      end
    end
  end

  initial begin
    abrir = 0; fim_aberta = 0; fim_fechada = 0;
    obstaculo = 0; rearme = 0; rst = 0;
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1, 1);
    // Normal open / hold / close
    step(1, 0, 0, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0, 0); idle(5);
    step(0, 0, 1, 0, 0, 0); idle(1);
    // Obstacle restarts the hold
    step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); idle(2);
    step(0, 0, 0, 1, 0, 0); idle(5);
    // Reversal beats the closed switch
    step(0, 0, 1, 1, 0, 0); step(0, 1, 0, 0, 0, 0); idle(5);
    step(0, 0, 1, 0, 0, 0);
    // Opening timeout, fault ignores abrir, re-arm and close
    step(1, 0, 0, 0, 0, 0); idle(10);
    step(1, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0); idle(2);
    step(0, 0, 1, 0, 0, 0);
    // Sensor conflict while opening
    step(1, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 1, 0, 0, 0);
    // Reset mid-close, then a fresh opening
    step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); idle(6);
    step(0, 0, 0, 0, 0, 1); step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    // Held abrir keeps the door open
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d exp=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
